stream_sequencer: RTL and testbench
===================================

STREAM_SEQUENCER -- requirements
Module: stream_sequencer

Interface
REQ-001 Parameter PREFILL, default 8, meaning the FIFO level (words) required before playback reads start; legal range 1..DEPTH-1.
REQ-002 Parameter SETTLE_FRAMES, default 2, meaning the number of fclk falling edges counted after lock before writes start; legal range 1..255.
REQ-003 Parameter DEPTH, default 16, meaning FIFO depth in words.
REQ-004 clk  input  1  main design clock (PLL output); the only clock in the block.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pll_lock  input  1  PLL lock status, asynchronous to clk.
REQ-007 fclk  input  1  I2S frame clock, asynchronous to clk.
REQ-008 user_sw  input  1  active-low restart button, asynchronous to clk.
REQ-009 fifo_level  input  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-010 fifo_full, fifo_empty  input  1 each  FIFO flags.
REQ-011 write_en  output  1  enables I2S capture and FIFO writes.
REQ-012 read_en  output  1  enables FIFO reads and marks S/PDIF samples valid.
REQ-013 fifo_flush  output  1  one-cycle pulse that clears the FIFO and receiver.
REQ-014 state  output  3  encoded FSM state: IDLE=0, SETTLE=1, FILL=2, RUN=3, FAULT=4.
REQ-015 err_count  output  8  saturating count of overflow/underflow faults.
REQ-016 red, green, blue  output  1 each  status LEDs, active-low.

Function
REQ-017 pll_lock, fclk and user_sw SHALL each pass through a 2-flop synchronizer before use.
REQ-018 frame_tick SHALL be a one-cycle pulse on each synchronized fclk 1->0 transition.
REQ-019 A restart event SHALL be a synchronized user_sw 1->0 transition.
REQ-020 IDLE: outputs write_en=0 and read_en=0; transitions to SETTLE when synced pll_lock=1, clearing the frame counter.
REQ-021 SETTLE: counts frame_ticks; on the tick that brings the count to SETTLE_FRAMES, transitions to FILL.
REQ-022 FILL: write_en=1 and read_en=0; transitions to RUN in the first cycle fifo_level>=PREFILL.
REQ-023 RUN: write_en=~fifo_full and read_en=~fifo_empty.
REQ-024 RUN overflow (frame_tick with fifo_full=1) or underflow (frame_tick with fifo_empty=1) SHALL cause a transition to FAULT.
REQ-025 FAULT: lasts exactly one cycle, asserts fifo_flush, increments err_count (saturating at 255), then transitions to SETTLE.
REQ-026 write_en and read_en SHALL be registered, updating one cycle after the state or flag change that causes them.
REQ-027 Synced pll_lock=0 in any non-IDLE state SHALL cause a transition to IDLE with a one-cycle fifo_flush; err_count is unchanged.
REQ-028 A restart event in any state SHALL cause a transition to IDLE with a one-cycle fifo_flush; lock loss and restart in the same cycle produce a single flush.
REQ-029 Priority, from highest to lowest, SHALL be: rst, lock loss, restart, overflow/underflow, normal transitions; overflow and underflow in the same cycle count once.
REQ-030 LEDs: red=0 in IDLE or FAULT; blue=0 in SETTLE or FILL; green=0 in RUN; every other LED is 1.

Reset
REQ-031 While rst=1, the block SHALL hold: state=IDLE, write_en=0, read_en=0, fifo_flush=0, err_count=0, frame counter=0, synchronizers=0, LEDs red=0 green=1 blue=1.
REQ-032 Reset mid-operation SHALL take effect on the next clk edge and discard any in-progress settle count.

Verification
REQ-033 Stimulus: rst deasserted, pll_lock=1, 2 fclk periods, fifo_level ramping 0..8 -> response: state goes 0->1->2 after the 2nd falling edge plus 3-4 cycles, enters 3 when level=8, and read_en rises 1 cycle after entering RUN.
REQ-034 Stimulus: in RUN, fifo_empty=1 at a frame_tick -> response: FAULT for 1 cycle, fifo_flush pulse width 1, err_count=1, then SETTLE.
REQ-035 Stimulus: 300 forced overflows -> response: err_count saturates at 255.
REQ-036 Stimulus: pll_lock dropped in RUN while a user_sw press lands in the same synced cycle -> response: single flush pulse, state=IDLE, write_en=read_en=0 next cycle.
REQ-037 Stimulus: rst pulsed during SETTLE after 1 frame -> response: all outputs at reset values, and after re-lock a full SETTLE_FRAMES=2 edges are required again.

Source files
------------

// File: rtl/stream_sequencer_if.sv
// rtl/stream_sequencer_if.sv - status/control bundle between the sequencer and its audio/FIFO environment
interface stream_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          pll_lock;
  logic          fclk;
  logic          user_sw;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          write_en;
  logic          read_en;
  logic          fifo_flush;
  logic [2:0]    state;
  logic [7:0]    err_count;
  logic          red;
  logic          green;
  logic          blue;

  modport slave (
    input  pll_lock, fclk, user_sw, fifo_level, fifo_full, fifo_empty,
    output write_en, read_en, fifo_flush, state, err_count, red, green, blue
  );

  modport master (
    output pll_lock, fclk, user_sw, fifo_level, fifo_full, fifo_empty,
    input  write_en, read_en, fifo_flush, state, err_count, red, green, blue
  );
endinterface

// File: rtl/stream_sequencer.sv
// rtl/stream_sequencer.sv - startup/playback sequencer for an I2S-to-S/PDIF FIFO bridge
module stream_sequencer #(
  parameter int PREFILL       = 8,
  parameter int SETTLE_FRAMES = 2,
  parameter int DEPTH         = 16
) (
  input logic               clk,
  input logic               rst,
  stream_sequencer_if.slave bus
);
  localparam int              LW          = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]   PREFILL_LVL = LW'(PREFILL);
  localparam logic [8:0]      SETTLE_LAST = 9'(SETTLE_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_FILL   = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_lock_sync;
  logic [1:0] r_fclk_sync;
  logic [1:0] r_sw_sync;
  logic       r_fclk_prev;
  logic       r_sw_prev;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_err_count;
  logic       r_write_en;
  logic       r_read_en;
  logic       r_flush;

  logic w_lock;
  logic w_frame_tick;
  logic w_restart;
  logic w_last_frame;

  assign w_lock       = r_lock_sync[1];
  assign w_frame_tick = r_fclk_prev & ~r_fclk_sync[1];
  assign w_restart    = r_sw_prev & ~r_sw_sync[1];
  assign w_last_frame = (({1'b0, r_frame_cnt} + 9'd1) == SETTLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lock_sync <= 2'b00;
      r_fclk_sync <= 2'b00;
      r_sw_sync   <= 2'b00;
      r_fclk_prev <= 1'b0;
      r_sw_prev   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_err_count <= 8'd0;
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], bus.pll_lock};
      r_fclk_sync <= {r_fclk_sync[0], bus.fclk};
      r_sw_sync   <= {r_sw_sync[0], bus.user_sw};
      r_fclk_prev <= r_fclk_sync[1];
      r_sw_prev   <= r_sw_sync[1];
      r_flush     <= 1'b0;

      // Enables follow the state and FIFO flags with one cycle of lag.
      r_write_en <= (r_state == S_FILL) || ((r_state == S_RUN) && !bus.fifo_full);
      r_read_en  <= (r_state == S_RUN) && !bus.fifo_empty;

      if ((r_state != S_IDLE) && !w_lock) begin
        r_state <= S_IDLE;
        r_flush <= 1'b1;
      end else if (w_restart) begin
        r_state <= S_IDLE;
        r_flush <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_lock) begin
              r_state     <= S_SETTLE;
              r_frame_cnt <= 8'd0;
            end
          end
          S_SETTLE: begin
            if (w_frame_tick) begin
              if (w_last_frame) r_state <= S_FILL;
              else              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
          S_FILL: begin
            if (bus.fifo_level >= PREFILL_LVL) r_state <= S_RUN;
          end
          S_RUN: begin
            // Flush is raised on entry so it is high exactly while FAULT is held.
            if (w_frame_tick && (bus.fifo_full || bus.fifo_empty)) begin
              r_state <= S_FAULT;
              r_flush <= 1'b1;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
          end
          S_FAULT: begin
            r_state     <= S_SETTLE;
            r_frame_cnt <= 8'd0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.write_en   = r_write_en;
  assign bus.read_en    = r_read_en;
  assign bus.fifo_flush = r_flush;
  assign bus.state      = r_state;
  assign bus.err_count  = r_err_count;
  assign bus.red        = !((r_state == S_IDLE) || (r_state == S_FAULT));
  assign bus.blue       = !((r_state == S_SETTLE) || (r_state == S_FILL));
  assign bus.green      = !(r_state == S_RUN);
endmodule

// File: tb/tb_stream_sequencer.sv
// tb/tb_stream_sequencer.sv - scoreboard bench for stream_sequencer
module tb_stream_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_sequencer_if #(.DEPTH(16)) bus ();

  stream_sequencer #(.PREFILL(8), .SETTLE_FRAMES(2), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int q_st[$];
  int q_fl[$];
  int prev_state = 0;
  int flush_w = 0;
  int exp_err = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.fclk = 1'b0;
    cyc(5);
    bus.fclk = 1'b1;
    cyc(5);
  endtask

  task automatic push_st(input int st, input int err);
    q_st.push_back(st * 256 + err);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_we"}, int'(bus.write_en), 0);
    chk({tag, "_re"}, int'(bus.read_en), 0);
    chk({tag, "_flush"}, int'(bus.fifo_flush), 0);
    chk({tag, "_err"}, int'(bus.err_count), 0);
    chk({tag, "_red"}, int'(bus.red), 0);
    chk({tag, "_green"}, int'(bus.green), 1);
    chk({tag, "_blue"}, int'(bus.blue), 1);
  endtask

  // Monitor: every state change and every flush pulse is checked against the queues.
  always @(negedge clk) begin
    int e;
    if (int'(bus.state) != prev_state) begin
      if (q_st.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_state got=%0d expected=none", bus.state);
      end else begin
        e = q_st.pop_front();
        chk("sb_state", int'(bus.state), e / 256);
        chk("sb_err", int'(bus.err_count), e % 256);
      end
      prev_state = int'(bus.state);
    end
    if (bus.fifo_flush) begin
      if (flush_w == 0) begin
        if (q_fl.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_flush got=1 expected=0 state=%0d", bus.state);
        end else begin
          chk("sb_flush_state", int'(bus.state), q_fl.pop_front());
        end
      end
      flush_w++;
    end else if (flush_w != 0) begin
      chk("flush_width", flush_w, 1);
      flush_w = 0;
    end
  end

  initial begin
    bus.pll_lock   = 1'b0;
    bus.fclk       = 1'b1;
    bus.user_sw    = 1'b1;
    bus.fifo_level = '0;
    bus.fifo_full  = 1'b0;
    bus.fifo_empty = 1'b1;
    rst = 1'b1;
    cyc(4);
    chk_reset("reset");

    // Startup: lock, two frames, prefill ramp.
    rst = 1'b0;
    cyc(2);
    push_st(1, 0);
    bus.pll_lock = 1'b1;
    cyc(5);
    frame();
    push_st(2, 0);
    bus.fclk = 1'b0;
    cyc(2);
    chk("settle_hold", int'(bus.state), 1);
    cyc(1);
    chk("fill_entry", int'(bus.state), 2);
    cyc(2);
    bus.fclk = 1'b1;
    chk("fill_we", int'(bus.write_en), 1);
    chk("fill_re", int'(bus.read_en), 0);
    chk("fill_blue", int'(bus.blue), 0);
    for (int lvl = 1; lvl <= 8; lvl++) begin
      bus.fifo_level = 5'(lvl);
      bus.fifo_empty = 1'b0;
      if (lvl == 8) push_st(3, 0);
      cyc(1);
    end
    chk("run_entry", int'(bus.state), 3);
    chk("run_re_lag", int'(bus.read_en), 0);
    cyc(1);
    chk("run_re", int'(bus.read_en), 1);
    chk("run_green", int'(bus.green), 0);

    // Underflow.
    bus.fifo_empty = 1'b1;
    push_st(4, 1);
    push_st(1, 1);
    q_fl.push_back(4);
    frame();
    chk("underflow_err", int'(bus.err_count), 1);
    chk("underflow_settle", int'(bus.state), 1);
    bus.fifo_empty = 1'b0;
    push_st(2, 1);
    push_st(3, 1);
    frame();
    frame();
    chk("rerun", int'(bus.state), 3);

    // Forced overflows to saturation.
    exp_err = 1;
    for (int i = 0; i < 300; i++) begin
      if (exp_err < 255) exp_err++;
      push_st(4, exp_err);
      push_st(1, exp_err);
      push_st(2, exp_err);
      push_st(3, exp_err);
      q_fl.push_back(4);
      bus.fifo_full = 1'b1;
      frame();
      bus.fifo_full = 1'b0;
      frame();
      frame();
    end
    chk("err_saturated", int'(bus.err_count), 255);

    // Lock loss and restart press in the same synchronized cycle.
    push_st(0, 255);
    q_fl.push_back(0);
    bus.pll_lock = 1'b0;
    bus.user_sw  = 1'b0;
    cyc(3);
    chk("lockloss_idle", int'(bus.state), 0);
    cyc(1);
    chk("lockloss_we", int'(bus.write_en), 0);
    chk("lockloss_re", int'(bus.read_en), 0);
    bus.user_sw = 1'b1;
    cyc(3);

    // Reset during SETTLE after one frame.
    push_st(1, 255);
    bus.pll_lock = 1'b1;
    cyc(5);
    frame();
    push_st(0, 0);
    rst = 1'b1;
    cyc(2);
    chk_reset("midreset");
    bus.fifo_level = '0;
    bus.fifo_empty = 1'b1;
    push_st(1, 0);
    rst = 1'b0;
    cyc(5);
    frame();
    chk("settle_restarted", int'(bus.state), 1);
    push_st(2, 0);
    frame();
    chk("settle_full_count", int'(bus.state), 2);

    cyc(5);
    chk("sb_state_drained", q_st.size(), 0);
    chk("sb_flush_drained", q_fl.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
